config_loader: RTL

Sequencer that drives the configuration latch bank. It accepts a stream of 32-bit configuration words over a valid/ready handshake. For each word it presents the data on a shared bus and pulses exactly one one-hot latch enable, with the setup/strobe/hold ordering that transparent latches require. It sits between the tile's configuration port (scan/bus front end) and the latch bank, which has inputs `io_d_in` and `io_configs_en`.

---
 rtl/config_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// config_loader: sequences 32-bit configuration words from a valid/ready stream
// onto the latch bank data bus, pulsing one one-hot latch enable per word with
// setup/strobe/hold ordering suitable for transparent latches.
//
// Optional feature: define CONFIG_LOADER_CHECKSUM_EN to accept a trailing XOR
// checksum word after the last configuration word and report mismatches on
// io_error. Without it, io_error is tied low.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 35
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    input  logic [WORD_W-1:0]    io_in_data,
    output logic                 io_in_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_error
);

    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StSetup  = 3'd2;
    localparam logic [2:0] StStrobe = 3'd3;
    localparam logic [2:0] StHold   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] ChkIdx = IDX_W'(NUM_WORDS);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic              error_q, error_d;
`endif

    // Next-state logic for the load sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        done_d  = done_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        acc_d   = acc_q;
        error_d = error_q;
`endif
        case (state_q)
            StIdle: begin
                if (io_start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    done_d  = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    acc_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            StLoad: begin
                if (io_in_valid) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    if (idx_q == ChkIdx) begin
                        // Trailer word: compared only, never driven onto the bus.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        error_d = (io_in_data != acc_q);
                    end else begin
                        dout_d  = io_in_data;
                        acc_d   = acc_q ^ io_in_data;
                        state_d = StSetup;
                    end
`else
                    dout_d  = io_in_data;
                    state_d = StSetup;
`endif
                end
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                state_d = StHold;
            end
            StHold: begin
                if (idx_q == LastIdx) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    idx_d   = ChkIdx;
                    state_d = StLoad;
`else
                    state_d = StIdle;
                    done_d  = 1'b1;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            acc_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            acc_q   <= acc_d;
            error_q <= error_d;
`endif
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        io_in_ready   = (state_q == StLoad);
        io_busy       = (state_q != StIdle);
        io_d_out      = dout_q;
        io_done       = done_q;
        io_configs_en = '0;
        if (state_q == StStrobe) begin
            io_configs_en = NUM_WORDS'(1) << idx_q;
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        io_error = error_q;
`else
        io_error = 1'b0;
`endif
    end

endmodule
